stage_id: RTL and testbench
===========================

STAGE_ID -- requirements
Module: stage_id

Interface
REQ-001 Parameter WORD_SIZE, default 16, datapath and instruction width.
REQ-002 Parameter NOP_INSTR, default 16'hF01C, instruction word inserted as a bubble.
REQ-003 clk  input  1  single pipeline clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 instruction  input  16  fetched word from IF stage.
REQ-006 PC_now  input  16  PC of fetched word.
REQ-007 nextPC  input  16  IF predicted next PC, carried for branch-resolution check.
REQ-008 flush  input  1  squash IF/ID and ID/EX contents (misprediction).
REQ-009 ex_mem_read  input  1  instruction in EX is a load (LWD).
REQ-010 ex_dest  input  2  destination register of instruction in EX.
REQ-011 wb_we, wb_addr[1:0], wb_data[15:0]  input  write-back port to register file.
REQ-012 data_hazard  output  1  combinational stall request to IF stage.
REQ-013 idex_valid, idex_instr[15:0], idex_pc[15:0], idex_npc[15:0]  output  registered ID/EX payload.
REQ-014 idex_rs_data, idex_rt_data, idex_imm  output  16 each  registered operands; imm sign-extended from instr[7:0].
REQ-015 idex_dest[1:0], idex_we  output  registered destination register and write enable.

Function
REQ-016 Fields: opcode=instr[15:12], rs=[11:10], rt=[9:8], rd=[7:6], imm=[7:0].
REQ-017 rs used by all opcodes except LHI(6), JMP(9), JAL(10); rt used by R-type(15), SWD(8), BNE(0), BEQ(1).
REQ-018 Dest: R-type -> rd with we=1 except non-writing funcs (WWD, JPR, HLT); LWD/ADI/ORI/LHI -> rt, we=1; JAL -> reg 2, we=1; all others we=0.
REQ-019 data_hazard SHALL be 1 when if_id_valid & ex_mem_read & ((rs used & rs==ex_dest) | (rt used & rt==ex_dest)), else 0; never 1 while flush=1.
REQ-020 Register file: 4 x 16 bits, write on posedge when wb_we=1.
REQ-021 Reads combinational with write-through: read of wb_addr while wb_we=1 returns wb_data same cycle.
REQ-022 IF/ID latch priority on posedge: flush -> valid=0, instr=NOP_INSTR; else data_hazard -> hold; else capture instruction, PC_now, nextPC, valid=1.
REQ-023 ID/EX latch priority on posedge: flush or data_hazard or !if_id_valid -> bubble (idex_valid=0, idex_we=0, idex_instr=NOP_INSTR); else load decoded payload.
REQ-024 Latency: word presented at cycle N appears on idex_* after posedge N+2 absent stalls.
REQ-025 Stall holds exactly as long as condition persists; one load-use stall costs one bubble in ID/EX.
REQ-026 Simultaneous flush and wb_we: register write SHALL still occur.
REQ-027 Immediate sign extension: idex_imm = {8{instr[7]}, instr[7:0]}.

Reset
REQ-028 reset_n=0 asynchronously clears all four registers to 0, both latches to bubble (valid=0, instr=NOP_INSTR, PC/npc=0, we=0, dest=0).
REQ-029 data_hazard=0 throughout reset; reset mid-stall drops the stall and held instruction.
REQ-030 First capture occurs on first posedge after reset_n rises.

Verification
REQ-031 Reset, then ADI r1,r0,5 (16'h4105) at PC 0 -> two cycles later idex_valid=1, idex_dest=1, idex_imm=16'h0005, idex_we=1.
REQ-032 wb_we=1, wb_addr=2, wb_data=16'hBEEF while ID reads rs=2 -> idex_rs_data=16'hBEEF next edge.
REQ-033 ex_mem_read=1, ex_dest=1, ID holds R-type ADD with rt=1 -> data_hazard=1, IF/ID held, ID/EX bubble; ex_mem_read drops -> instruction issues next edge.
REQ-034 Load-use match on rt for ADI (rt not used) -> data_hazard=0.
REQ-035 flush=1 with valid IF/ID and hazard pending -> data_hazard=0, both latches bubble after edge.
REQ-036 reset_n low mid-stall with r3=16'h1234 -> all idex outputs bubble, r3 reads 0 after release.

Source files
------------

// File: rtl/stage_id.sv
// ---------------------------------------------------------------------------
// stage_id: instruction-decode stage of a 5-stage pipeline.
//
// Holds the IF/ID latch, a 4x16 register file with write-through reads, the
// load-use hazard detector and the ID/EX latch.
//
// Ports
//   clk, reset_n              pipeline clock, asynchronous active-low reset
//   instruction, PC_now,      word fetched by IF, its PC and IF's predicted
//   nextPC                    next PC
//   flush                     squash IF/ID and ID/EX (branch misprediction)
//   ex_mem_read, ex_dest      load in EX and its destination register
//   wb_we, wb_addr, wb_data   register-file write-back port
//   data_hazard               combinational stall request to IF
//   idex_*                    registered payload handed to EX
// ---------------------------------------------------------------------------
module stage_id #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 16'hF01C
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic [WORD_SIZE-1:0] PC_now,
    input  logic [WORD_SIZE-1:0] nextPC,
    input  logic                 flush,
    input  logic                 ex_mem_read,
    input  logic [1:0]           ex_dest,
    input  logic                 wb_we,
    input  logic [1:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 data_hazard,
    output logic                 idex_valid,
    output logic [WORD_SIZE-1:0] idex_instr,
    output logic [WORD_SIZE-1:0] idex_pc,
    output logic [WORD_SIZE-1:0] idex_npc,
    output logic [WORD_SIZE-1:0] idex_rs_data,
    output logic [WORD_SIZE-1:0] idex_rt_data,
    output logic [WORD_SIZE-1:0] idex_imm,
    output logic [1:0]           idex_dest,
    output logic                 idex_we
);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_RTY = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    function automatic logic uses_rs(input logic [3:0] op);
        return !(op == OP_LHI || op == OP_JMP || op == OP_JAL);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        return (op == OP_RTY || op == OP_SWD || op == OP_BNE || op == OP_BEQ);
    endfunction

    // Returns {we, dest}; dest is forced to 0 for non-writing instructions.
    function automatic logic [2:0] dest_of(input logic [WORD_SIZE-1:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        if (op == OP_RTY) begin
            if (ins[5:0] == FN_JPR || ins[5:0] == FN_WWD || ins[5:0] == FN_HLT)
                return 3'b000;
            return {1'b1, ins[7:6]};
        end
        if (op == OP_LWD || op == OP_ADI || op == OP_ORI || op == OP_LHI)
            return {1'b1, ins[9:8]};
        if (op == OP_JAL)
            return 3'b110;
        return 3'b000;
    endfunction

    function automatic logic signed [WORD_SIZE-1:0] sext_imm(input logic [7:0] imm8);
        return $signed({{(WORD_SIZE-8){imm8[7]}}, imm8});
    endfunction

    logic [WORD_SIZE-1:0] rf [4];

    logic                 if_id_valid_p0;
    logic [WORD_SIZE-1:0] instr_p0;
    logic [WORD_SIZE-1:0] pc_p0;
    logic [WORD_SIZE-1:0] npc_p0;

    logic [3:0]           opcode;
    logic [1:0]           rs;
    logic [1:0]           rt;
    logic [WORD_SIZE-1:0] rs_data;
    logic [WORD_SIZE-1:0] rt_data;
    logic [2:0]           dest_we;
    logic signed [WORD_SIZE-1:0] imm_sx;

    assign opcode  = instr_p0[15:12];
    assign rs      = instr_p0[11:10];
    assign rt      = instr_p0[9:8];
    assign dest_we = dest_of(instr_p0);
    assign imm_sx  = sext_imm(instr_p0[7:0]);

    // Write-through: a value being written back this cycle is visible to the
    // instruction decoding in the same cycle.
    assign rs_data = (wb_we && wb_addr == rs) ? wb_data : rf[rs];
    assign rt_data = (wb_we && wb_addr == rt) ? wb_data : rf[rt];

    // Flush outranks the stall: a squashed instruction must not hold IF.
    assign data_hazard = reset_n && !flush && if_id_valid_p0 && ex_mem_read &&
                         ((uses_rs(opcode) && rs == ex_dest) ||
                          (uses_rt(opcode) && rt == ex_dest));

    // Register file; written even while flushing since write-back belongs to
    // an older, committed instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // ---- IF/ID boundary ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_id_valid_p0 <= 1'b0;
            instr_p0       <= NOP_INSTR;
            pc_p0          <= '0;
            npc_p0         <= '0;
        end else if (flush) begin
            if_id_valid_p0 <= 1'b0;
            instr_p0       <= NOP_INSTR;
            pc_p0          <= '0;
            npc_p0         <= '0;
        end else if (!data_hazard) begin
            if_id_valid_p0 <= 1'b1;
            instr_p0       <= instruction;
            pc_p0          <= PC_now;
            npc_p0         <= nextPC;
        end
    end

    // ---- ID/EX boundary ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_valid   <= 1'b0;
            idex_instr   <= NOP_INSTR;
            idex_pc      <= '0;
            idex_npc     <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_dest    <= '0;
            idex_we      <= 1'b0;
        end else if (flush || data_hazard || !if_id_valid_p0) begin
            idex_valid   <= 1'b0;
            idex_instr   <= NOP_INSTR;
            idex_pc      <= '0;
            idex_npc     <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_dest    <= '0;
            idex_we      <= 1'b0;
        end else begin
            idex_valid   <= 1'b1;
            idex_instr   <= instr_p0;
            idex_pc      <= pc_p0;
            idex_npc     <= npc_p0;
            idex_rs_data <= rs_data;
            idex_rt_data <= rt_data;
            idex_imm     <= $unsigned(imm_sx);
            idex_dest    <= dest_we[1:0];
            idex_we      <= dest_we[2];
        end
    end

endmodule

// File: tb/tb_stage_id.sv
module tb_stage_id;

    localparam logic [15:0] NOP = 16'hF01C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instruction, PC_now, nextPC;
    logic        flush, ex_mem_read;
    logic [1:0]  ex_dest;
    logic        wb_we;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        data_hazard;
    logic        idex_valid;
    logic [15:0] idex_instr, idex_pc, idex_npc, idex_rs_data, idex_rt_data, idex_imm;
    logic [1:0]  idex_dest;
    logic        idex_we;

    int vectors = 0;
    int miscompares = 0;

    stage_id dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .PC_now(PC_now),
        .nextPC(nextPC), .flush(flush), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .data_hazard(data_hazard),
        .idex_valid(idex_valid), .idex_instr(idex_instr), .idex_pc(idex_pc),
        .idex_npc(idex_npc), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
        .idex_imm(idex_imm), .idex_dest(idex_dest), .idex_we(idex_we)
    );

    always #5 clk = ~clk;

    // Reference model: register array, contents of the decode slot, and the
    // payload expected to reach EX.
    logic [15:0] m_rf [4];
    logic        m_v;
    logic [15:0] m_instr, m_pc, m_npc;
    logic [15:0] e_instr, e_pc, e_npc, e_rs, e_rt, e_imm;
    logic        e_valid, e_we;
    logic [1:0]  e_dest;

    function automatic bit reads_rs(logic [15:0] ins);
        int op = int'(ins[15:12]);
        return !(op == 6 || op == 9 || op == 10);
    endfunction

    function automatic bit reads_rt(logic [15:0] ins);
        int op = int'(ins[15:12]);
        return (op == 15 || op == 8 || op == 0 || op == 1);
    endfunction

    function automatic bit writes(logic [15:0] ins);
        int op = int'(ins[15:12]);
        int fn = int'(ins[5:0]);
        if (op == 15) return !(fn == 25 || fn == 28 || fn == 29);
        return (op == 4 || op == 5 || op == 6 || op == 7 || op == 10);
    endfunction

    function automatic logic [1:0] dest_reg(logic [15:0] ins);
        int op = int'(ins[15:12]);
        if (!writes(ins)) return 2'd0;
        if (op == 15) return ins[7:6];
        if (op == 10) return 2'd2;
        return ins[9:8];
    endfunction

    function automatic bit model_hazard();
        if (!reset_n || flush || !m_v || !ex_mem_read) return 0;
        return (reads_rs(m_instr) && m_instr[11:10] == ex_dest) ||
               (reads_rt(m_instr) && m_instr[9:8] == ex_dest);
    endfunction

    function automatic logic [15:0] rd_reg(logic [1:0] a);
        return (wb_we && wb_addr == a) ? wb_data : m_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
        m_v = 0; m_instr = NOP; m_pc = 0; m_npc = 0;
        e_valid = 0; e_instr = NOP; e_pc = 0; e_npc = 0;
        e_rs = 0; e_rt = 0; e_imm = 0; e_dest = 0; e_we = 0;
    endtask

    task automatic idle();
        flush = 0; ex_mem_read = 0; ex_dest = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    // Advance one clock, updating the model from the inputs in force before
    // the edge; returns at edge + 1.
    task automatic tick();
        bit hz;
        hz = model_hazard();
        if (flush || hz || !m_v) begin
            e_valid = 0; e_instr = NOP; e_pc = 0; e_npc = 0;
            e_rs = 0; e_rt = 0; e_imm = 0; e_dest = 0; e_we = 0;
        end else begin
            e_valid = 1; e_instr = m_instr; e_pc = m_pc; e_npc = m_npc;
            e_rs = rd_reg(m_instr[11:10]);
            e_rt = rd_reg(m_instr[9:8]);
            e_imm = 16'($signed(m_instr[7:0]));
            e_dest = dest_reg(m_instr);
            e_we = writes(m_instr);
        end
        if (flush) begin
            m_v = 0; m_instr = NOP; m_pc = 0; m_npc = 0;
        end else if (!hz) begin
            m_v = 1; m_instr = instruction; m_pc = PC_now; m_npc = nextPC;
        end
        if (wb_we) m_rf[wb_addr] = wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        instruction = 16'h0; PC_now = 0; nextPC = 0;
        reset_n = 0;
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle();
        instruction = 16'h4105; ex_mem_read = 1;
        reset_n = 0;
        model_clear();
        #2;
        vectors++;
        if ({idex_valid, idex_we, idex_dest, idex_instr, idex_pc, idex_npc} !== {1'b0, 1'b0, 2'b0, NOP, 16'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_idex: valid=%0b we=%0b dest=%0d instr=%h pc=%h npc=%h expected 0 0 0 %h 0 0", idex_valid, idex_we, idex_dest, idex_instr, idex_pc, idex_npc, NOP);
        end
        vectors++;
        if (data_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hazard: got %b expected 0", data_hazard);
        end
        @(posedge clk); #1;
        vectors++;
        if (idex_valid !== 1'b0 || {idex_rs_data, idex_rt_data, idex_imm} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b rs=%h rt=%h imm=%h expected 0", idex_valid, idex_rs_data, idex_rt_data, idex_imm);
        end
        reset_n = 1;
        ex_mem_read = 0;
    endtask

    task automatic test_adi();
        apply_reset();
        instruction = 16'h4105; PC_now = 16'h0; nextPC = 16'h1;
        tick();
        instruction = NOP; PC_now = 16'h1; nextPC = 16'h2;
        vectors++;
        if (idex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL adi_latency: idex_valid=%b after one edge expected 0", idex_valid);
        end
        tick();
        vectors++;
        if ({idex_valid, idex_dest, idex_imm, idex_we, idex_pc, idex_npc, idex_instr} !== {1'b1, 2'd1, 16'h0005, 1'b1, 16'h0, 16'h1, 16'h4105}) begin
            miscompares++;
            $display("FAIL adi_issue: valid=%b dest=%0d imm=%h we=%b pc=%h npc=%h instr=%h expected 1 1 0005 1 0000 0001 4105", idex_valid, idex_dest, idex_imm, idex_we, idex_pc, idex_npc, idex_instr);
        end
        instruction = 16'h4480;
        tick(); tick();
        vectors++;
        if (idex_imm !== 16'hFF80 || idex_dest !== 2'd0) begin
            miscompares++;
            $display("FAIL imm_sext: imm=%h dest=%0d expected ff80 0", idex_imm, idex_dest);
        end
    endtask

    task automatic test_write_through();
        apply_reset();
        instruction = 16'hF800; PC_now = 16'h10; nextPC = 16'h11;
        tick();
        wb_we = 1; wb_addr = 2; wb_data = 16'hBEEF;
        tick();
        vectors++;
        if (idex_rs_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL write_through: rs_data=%h expected beef", idex_rs_data);
        end
        wb_we = 0;
        tick();
        vectors++;
        if (idex_rs_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rf_write: rs_data=%h expected beef", idex_rs_data);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        instruction = 16'hF1C0; PC_now = 16'h20; nextPC = 16'h21;
        tick();
        instruction = 16'h4105; PC_now = 16'h21; nextPC = 16'h22;
        ex_mem_read = 1; ex_dest = 1;
        #1;
        vectors++;
        if (data_hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_hazard: got %b expected 1", data_hazard);
        end
        tick();
        vectors++;
        if (idex_valid !== 1'b0 || idex_instr !== NOP || idex_we !== 1'b0 || data_hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_bubble: valid=%b instr=%h we=%b hazard=%b expected 0 %h 0 1", idex_valid, idex_instr, idex_we, data_hazard, NOP);
        end
        ex_mem_read = 0;
        #1;
        vectors++;
        if (data_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_release: hazard=%b expected 0", data_hazard);
        end
        tick();
        vectors++;
        if (idex_valid !== 1'b1 || idex_instr !== 16'hF1C0 || idex_pc !== 16'h20 || idex_dest !== 2'd3) begin
            miscompares++;
            $display("FAIL lu_issue: valid=%b instr=%h pc=%h dest=%0d expected 1 f1c0 0020 3", idex_valid, idex_instr, idex_pc, idex_dest);
        end
        tick();
        vectors++;
        if (idex_instr !== 16'h4105 || idex_pc !== 16'h21) begin
            miscompares++;
            $display("FAIL lu_next: instr=%h pc=%h expected 4105 0021", idex_instr, idex_pc);
        end
    endtask

    task automatic test_adi_no_hazard();
        apply_reset();
        instruction = 16'h4105;
        tick();
        ex_mem_read = 1; ex_dest = 1;
        #1;
        vectors++;
        if (data_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL adi_rt_unused: hazard=%b expected 0", data_hazard);
        end
        ex_dest = 0;
        #1;
        vectors++;
        if (data_hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL adi_rs_match: hazard=%b expected 1", data_hazard);
        end
        ex_mem_read = 0;
    endtask

    task automatic test_flush();
        apply_reset();
        instruction = 16'hF1C0;
        tick();
        instruction = 16'h4105;
        ex_mem_read = 1; ex_dest = 1; flush = 1;
        wb_we = 1; wb_addr = 3; wb_data = 16'h5A5A;
        #1;
        vectors++;
        if (data_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hazard: hazard=%b expected 0", data_hazard);
        end
        tick();
        vectors++;
        if (idex_valid !== 1'b0 || idex_instr !== NOP) begin
            miscompares++;
            $display("FAIL flush_idex: valid=%b instr=%h expected 0 %h", idex_valid, idex_instr, NOP);
        end
        idle();
        instruction = 16'hFC00;
        tick();
        vectors++;
        if (idex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ifid: valid=%b expected 0", idex_valid);
        end
        tick();
        vectors++;
        if (idex_valid !== 1'b1 || idex_rs_data !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL flush_wb: valid=%b rs_data=%h expected 1 5a5a", idex_valid, idex_rs_data);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        wb_we = 1; wb_addr = 3; wb_data = 16'h1234;
        instruction = 16'hFD00;
        tick();
        wb_we = 0;
        ex_mem_read = 1; ex_dest = 1;
        tick();
        #1;
        reset_n = 0;
        #1;
        vectors++;
        if (idex_valid !== 1'b0 || idex_instr !== NOP || idex_we !== 1'b0 || data_hazard !== 1'b0 || idex_pc !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_stall: valid=%b instr=%h we=%b hazard=%b pc=%h expected 0 %h 0 0 0", idex_valid, idex_instr, idex_we, data_hazard, idex_pc, NOP);
        end
        model_clear();
        idle();
        instruction = 16'hFC00;
        @(posedge clk); #1;
        reset_n = 1;
        tick(); tick();
        vectors++;
        if (idex_valid !== 1'b1 || idex_instr !== 16'hFC00 || idex_rs_data !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_regs: valid=%b instr=%h rs_data=%h expected 1 fc00 0000", idex_valid, idex_instr, idex_rs_data);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            instruction = 16'($urandom);
            PC_now = 16'(n);
            nextPC = 16'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            ex_mem_read = $urandom_range(0, 1);
            ex_dest = 2'($urandom);
            wb_we = $urandom_range(0, 1);
            wb_addr = 2'($urandom);
            wb_data = 16'($urandom);
            #1;
            vectors++;
            if (data_hazard !== 1'(model_hazard())) begin
                miscompares++;
                $display("FAIL rnd_hazard[%0d]: got %b expected %b", n, data_hazard, model_hazard());
            end
            tick();
            vectors++;
            if ({idex_valid, idex_instr, idex_pc, idex_npc, idex_rs_data, idex_rt_data, idex_imm, idex_dest, idex_we} !==
                {e_valid, e_instr, e_pc, e_npc, e_rs, e_rt, e_imm, e_dest, e_we}) begin
                miscompares++;
                $display("FAIL rnd_idex[%0d]: got v=%b i=%h pc=%h npc=%h rs=%h rt=%h imm=%h d=%0d we=%b expected v=%b i=%h pc=%h npc=%h rs=%h rt=%h imm=%h d=%0d we=%b",
                         n, idex_valid, idex_instr, idex_pc, idex_npc, idex_rs_data, idex_rt_data, idex_imm, idex_dest, idex_we,
                         e_valid, e_instr, e_pc, e_npc, e_rs, e_rt, e_imm, e_dest, e_we);
            end
        end
        idle();
    endtask

    initial begin
        reset_n = 0;
        idle();
        instruction = 0; PC_now = 0; nextPC = 0;
        model_clear();
        @(posedge clk); #1;
        test_reset();
        test_adi();
        test_write_through();
        test_load_use();
        test_adi_no_hazard();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
